mac_result_accumulator: RTL and testbench

Consumer-side companion to the 4-lane 8-bit MAC primitive (18-bit dot-product result, registered inputs). It tracks which cycles issued operands into the MAC and realigns those issue tags with the MAC's fixed result latency. It accumulates signed 18-bit partial results into a saturating 32-bit sum and emits one sum per dot product through a small output buffer using a valid/ready handshake. A credit check on the issue side ensures no result is ever dropped when the downstream stalls.

---
 rtl/mac_acc_pkg.sv | 37 +++
 rtl/mac_acc_out_fifo.sv | 53 +++++
 rtl/mac_result_accumulator.sv | 101 ++++++++++
 tb/tb_mac_result_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// Shared widths, saturation limits, tag type and saturating adder for the
// MAC result accumulator.
package mac_acc_pkg;

  localparam int unsigned DEF_RESULT_WIDTH = 18;
  localparam int unsigned DEF_ACC_WIDTH    = 32;

  localparam logic [DEF_ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
  localparam logic [DEF_ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(DEF_ACC_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  typedef struct packed {
    logic [DEF_ACC_WIDTH-1:0] sum;
    logic                     sat;
  } sat_res_t;

  // Two's complement add clamped to [ACC_MIN, ACC_MAX]; sat flags a clamp.
  function automatic sat_res_t sat_add(input logic [DEF_ACC_WIDTH-1:0] a,
                                       input logic [DEF_ACC_WIDTH-1:0] b);
    logic [DEF_ACC_WIDTH:0] wide;
    sat_res_t               res;
    wide = {a[DEF_ACC_WIDTH-1], a} + {b[DEF_ACC_WIDTH-1], b};
    if (wide[DEF_ACC_WIDTH] != wide[DEF_ACC_WIDTH-1]) begin
      res.sat = 1'b1;
      res.sum = wide[DEF_ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      res.sat = 1'b0;
      res.sum = wide[DEF_ACC_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_acc_out_fifo.sv
// Synchronous output FIFO holding completed dot-product sums; exposes its
// occupancy so the issue side can reserve slots ahead of time.
module mac_acc_out_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             pop_data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Credits are reserved at issue, so a push can never meet a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o))
    else $error("mac_acc_out_fifo: push into full buffer");

endmodule

// File: rtl/mac_result_accumulator.sv
// Realigns issue tags with the MAC result latency, accumulates saturating
// dot-product sums and buffers them behind a credit-checked issue port.
module mac_result_accumulator
  import mac_acc_pkg::*;
#(
  parameter int unsigned MAC_LATENCY  = 2,
  parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int unsigned BUF_DEPTH    = 4
) (
  input  logic                    clock0,
  input  logic                    resetn,
  input  logic                    issue_valid,
  input  logic                    issue_last,
  output logic                    issue_ready,
  input  logic [RESULT_WIDTH-1:0] mac_result,
  output logic [ACC_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned PW = $clog2(MAC_LATENCY + 1);

  tag_t                 tag_q [MAC_LATENCY];
  tag_t                 res_tag;
  logic                 issue_fire;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] mac_ext;
  logic                 ovf_q, ovf_d;
  logic [PW-1:0]        pend_q, pend_d;
  logic                 ready_q, ready_d;
  logic                 push, pop, buf_empty, buf_full;
  logic [ACC_WIDTH-1:0] push_data;
  logic [CW-1:0]        buf_count, count_nxt;
  sat_res_t             add;

  assign res_tag     = tag_q[MAC_LATENCY-1];
  assign issue_fire  = issue_valid & ready_q;
  assign issue_ready = ready_q;
  assign overflow    = ovf_q;
  assign out_valid   = ~buf_empty;
  assign pop         = out_valid & out_ready;
  assign mac_ext     = {{(ACC_WIDTH-RESULT_WIDTH){mac_result[RESULT_WIDTH-1]}}, mac_result};

  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    add       = sat_add(acc_q, mac_ext);
    push_data = add.sum;
    if (res_tag.valid) begin
      ovf_d = ovf_q | add.sat;
      if (res_tag.last) begin
        push  = 1'b1;
        acc_d = '0;
      end else begin
        acc_d = add.sum;
      end
    end
    pend_d    = pend_q + PW'(issue_fire & issue_last) - PW'(res_tag.valid & res_tag.last);
    count_nxt = buf_count + CW'(push) - CW'(pop);
    // Registered credit check: reflects the occupancy that will exist next cycle.
    ready_d   = (32'(count_nxt) + 32'(pend_d)) < BUF_DEPTH;
  end

  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(MAC_LATENCY); i++) tag_q[i] <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      tag_q[0].valid <= issue_fire;
      tag_q[0].last  <= issue_fire & issue_last;
      for (int i = 1; i < int'(MAC_LATENCY); i++) tag_q[i] <= tag_q[i-1];
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  mac_acc_out_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_out_fifo (
    .clk         (clock0),
    .rst_n       (resetn),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .empty_o     (buf_empty),
    .full_o      (buf_full),
    .count_o     (buf_count)
  );

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Directed bench for mac_result_accumulator with a two-stage MAC stand-in.
module tb_mac_result_accumulator;

  localparam logic [17:0] JUNK = 18'h15555;

  logic        clock0 = 1'b0;
  logic        resetn;
  logic        issue_valid, issue_last, issue_ready;
  logic [17:0] mac_result;
  logic [31:0] out_data;
  logic        out_valid, out_ready, overflow;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] cur_val, stage0;
  logic        last_acc;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  mac_result_accumulator dut (
    .clock0      (clock0),
    .resetn      (resetn),
    .issue_valid (issue_valid),
    .issue_last  (issue_last),
    .issue_ready (issue_ready),
    .mac_result  (mac_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow)
  );

  always #5 clock0 = ~clock0;

  // One clock: log handshakes, then advance the MAC model (result two edges after issue).
  task automatic tick();
    logic        xfer, issued;
    logic [31:0] d;
    logic [17:0] v;
    xfer   = out_valid & out_ready;
    d      = out_data;
    issued = issue_valid & issue_ready;
    v      = cur_val;
    @(posedge clock0);
    #1;
    if (xfer) got_q.push_back(d);
    last_acc   = issued;
    mac_result = stage0;
    stage0     = issued ? v : JUNK;
  endtask

  task automatic drive(input logic l, input logic [17:0] val);
    issue_valid = 1'b1;
    issue_last  = l;
    cur_val     = val;
    tick();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b1; issue_valid = 1'b0; issue_last = 1'b0; out_ready = 1'b0;
    mac_result = JUNK; stage0 = JUNK; cur_val = '0;
    #2 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    idle(2);
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_two_group();
    got_q.delete();
    out_ready = 1'b1;
    drive(1'b0, 18'd100);
    drive(1'b1, 18'(-30));
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_group_early got %b exp 0", out_valid); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_group_lat1 got %b exp 0", out_valid); end
    idle(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL two_group_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'd70) begin errors++; $display("FAIL two_group_data got %0d exp 70", out_data); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_group_one_cycle got %b exp 0", out_valid); end
    idle(3);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL two_group_count got %0d exp 1", got_q.size()); end
  endtask

  task automatic test_negative();
    got_q.delete();
    out_ready = 1'b1;
    drive(1'b1, 18'h20000);
    idle(2);
    checks++; if (out_data !== 32'hFFFE0000) begin errors++; $display("FAIL negative_data got %h exp fffe0000", out_data); end
    idle(3);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL negative_count got %0d exp 1", got_q.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL negative_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_saturation();
    got_q.delete();
    out_ready = 1'b1;
    // 16382*131071 + 78526 = 2^31 - 200000
    for (int i = 0; i < 16382; i++) drive(1'b0, 18'h1FFFF);
    drive(1'b0, 18'd78526);
    idle(3);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_preload_overflow got %b exp 0", overflow); end
    drive(1'b0, 18'h1FFFF);
    drive(1'b0, 18'h1FFFF);
    drive(1'b1, 18'h1FFFF);
    idle(4);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL sat_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat_data got %h exp 7fffffff", got_q[0]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got %b exp 1", overflow); end
    got_q.delete();
    drive(1'b1, 18'd5);
    idle(4);
    checks++; if (got_q.size() != 1 || got_q[0] !== 32'd5) begin errors++; $display("FAIL sat_after_data got n=%0d exp single 5", got_q.size()); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    got_q.delete();
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 18'(i + 1));
      if (last_acc) acc_cnt++;
    end
    checks++; if (acc_cnt != 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", acc_cnt); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", issue_ready); end
    idle(3);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held got %b exp 0", issue_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin errors++; $display("FAIL bp_head got v=%b d=%0d exp v=1 d=1", out_valid, out_data); end
    out_ready = 1'b1;
    idle(6);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++; if (got_q[i] !== 32'(i + 1)) begin errors++; $display("FAIL bp_order[%0d] got %0d exp %0d", i, got_q[i], i + 1); end
    end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", issue_ready); end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (issue_ready) begin
        drive(1'b1, 18'(40 + i));
        if (last_acc) exp_q.push_back(32'(40 + i));
      end else idle(1);
    end
    idle(3);
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (issue_ready) begin
        drive(1'b1, 18'(60 + i));
        if (last_acc) exp_q.push_back(32'(60 + i));
      end else idle(1);
    end
    idle(8);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    out_ready = 1'b0;
    drive(1'b1, 18'd7);
    drive(1'b1, 18'd8);
    drive(1'b1, 18'd9);
    resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", out_data); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", issue_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got %b exp 0", overflow); end
    idle(1);
    resetn = 1'b1;
    idle(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale got %b exp 0", out_valid); end
    out_ready = 1'b1;
    drive(1'b1, 18'd5);
    idle(4);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_mid_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 32'd5) begin errors++; $display("FAIL rst_mid_data5 got %0d exp 5", got_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_two_group();
    test_negative();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
